// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial WIDTH-bit adder/subtractor with start/busy/done handshake
//
// Ports:
//   clk   - system clock, rising edge
//   rst   - synchronous active-high reset
//   start - begin a new operation (accepted in IDLE or DONE)
//   sub   - 0: a+b, 1: a-b (captured with start)
//   a, b  - WIDTH-bit operands (captured with start)
//   busy  - high while digits are being processed
//   done  - one-cycle pulse when s/cout/ovf become valid
//   s     - sum/difference, held until the next accepted start
//   cout  - carry out of MSB (subtract: 1 = no borrow)
//   ovf   - two's-complement signed overflow
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int N = WIDTH / DIGIT;
    localparam int CW = N > 1 ? $clog2(N) : 1;
    localparam logic [WIDTH-1:0] DMASK = WIDTH'({DIGIT{1'b1}});

    generate
        if (WIDTH < 2 || WIDTH % DIGIT != 0) begin : g_bad_params
            $error("addsub_serial: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] opa, opb;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last;
    logic [DIGIT-1:0] da, db;
    logic [DIGIT:0]   dsum;
    logic [31:0]      pos;

    always_comb begin
        accept    = start && state != RUN;
        last      = cnt == CW'(N - 1);
        pos       = 32'(cnt) * 32'(DIGIT);
        da        = DIGIT'(opa >> pos);
        db        = DIGIT'(opb >> pos);
        dsum      = {1'b0, da} + {1'b0, db} + (DIGIT + 1)'(carry);
        state_nxt = state == RUN ? (last ? DONE : RUN) : (accept ? RUN : IDLE);
    end

    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                // subtraction is a + ~b + 1: invert b once and seed the carry
                opa   <= a;
                opb   <= sub ? ~b : b;
                carry <= sub;
                cnt   <= '0;
                s     <= '0;
                cout  <= 1'b0;
                ovf   <= 1'b0;
            end else if (state == RUN) begin
                s     <= (s & ~(DMASK << pos)) | (WIDTH'(dsum[DIGIT-1:0]) << pos);
                carry <= dsum[DIGIT];
                cnt   <= cnt + 1'b1;
                if (last) begin
                    cout <= dsum[DIGIT];
                    // carry into the MSB is recovered as sum_msb ^ a_msb ^ b_msb
                    ovf  <= dsum[DIGIT-1] ^ opa[WIDTH-1] ^ opb[WIDTH-1] ^ dsum[DIGIT];
                end
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed-vector bench for addsub_serial at DIGIT = 1, 4 and 8
module tb_addsub_serial;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sub = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy1, busy4, busy8, done1, done4, done8;
    logic       cout1, cout4, cout8, ovf1, ovf4, ovf8;
    logic [7:0] s1, s4, s8;
    logic [2:0] bz, dn, cv, ov;
    logic [7:0] sv [3];
    int         nvec = 0;
    int         nerr = 0;
    int         nn [3] = '{8, 2, 1};

    always #5 clk = ~clk;

    addsub_serial #(.WIDTH(8), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy1), .done(done1), .s(s1), .cout(cout1), .ovf(ovf1));
    addsub_serial #(.WIDTH(8), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy4), .done(done4), .s(s4), .cout(cout4), .ovf(ovf4));
    addsub_serial #(.WIDTH(8), .DIGIT(8)) u8 (.clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy8), .done(done8), .s(s8), .cout(cout8), .ovf(ovf8));

    always_comb begin
        bz    = {busy8, busy4, busy1};
        dn    = {done8, done4, done1};
        cv    = {cout8, cout4, cout1};
        ov    = {ovf8, ovf4, ovf1};
        sv[0] = s1;
        sv[1] = s4;
        sv[2] = s8;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_all(input string tag, input logic [7:0] va, input logic [7:0] vb, input logic vs,
                           input logic [7:0] es, input logic ec, input logic eo);
        int         nb [3] = '{0, 0, 0};
        int         nd [3] = '{0, 0, 0};
        int         dc [3] = '{0, 0, 0};
        int         both = 0;
        logic [7:0] rs [3];
        logic       rc [3];
        logic       ro [3];
        a = va; b = vb; sub = vs; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~va; b = ~vb; sub = ~vs;
        for (int c = 1; c <= 12; c++) begin
            for (int k = 0; k < 3; k++) begin
                if (bz[k]) nb[k]++;
                if (bz[k] && dn[k]) both++;
                if (dn[k]) begin
                    if (nd[k] == 0) begin
                        dc[k] = c; rs[k] = sv[k]; rc[k] = cv[k]; ro[k] = ov[k];
                    end
                    nd[k]++;
                end
            end
            tick();
        end
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s d%0d busy cycles", tag, 8 / nn[k]), nb[k], nn[k]);
            chk($sformatf("%s d%0d done pulses", tag, 8 / nn[k]), nd[k], 1);
            chk($sformatf("%s d%0d done cycle", tag, 8 / nn[k]), dc[k], nn[k] + 1);
            if (nd[k] != 0) begin
                chk($sformatf("%s d%0d s", tag, 8 / nn[k]), rs[k], es);
                chk($sformatf("%s d%0d cout", tag, 8 / nn[k]), rc[k], ec);
                chk($sformatf("%s d%0d ovf", tag, 8 / nn[k]), ro[k], eo);
            end
            chk($sformatf("%s d%0d s held", tag, 8 / nn[k]), sv[k], es);
            chk($sformatf("%s d%0d cout held", tag, 8 / nn[k]), cv[k], ec);
        end
        chk({tag, " busy&done"}, both, 0);
    endtask

    initial begin
        int c;
        int ndone;
        tick();
        tick();
        rst = 1'b0;
        chk("reset busy", bz, 0);
        chk("reset done", dn, 0);
        chk("reset s", {s8, s4, s1}, 0);
        chk("reset cout/ovf", {cv, ov}, 0);

        run_all("3C+0F", 8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
        run_all("7F+01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run_all("FF+01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_all("05-07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        run_all("80-01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        run_all("9C+64", 8'h9C, 8'h64, 1'b0, 8'h00, 1'b1, 1'b0);

        // start in RUN is ignored; start in DONE is taken back-to-back
        a = 8'h10; b = 8'h20; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        a = 8'hAA; b = 8'h55; sub = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        c = 4;
        while (!done1 && c < 20) begin
            tick();
            c++;
        end
        chk("ignore done cycle", c, 9);
        chk("ignore s", s1, 8'h30);
        chk("ignore cout/ovf", {cout1, ovf1}, 2'b00);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b busy", busy1, 1'b1);
        c = 1;
        while (!done1 && c < 20) begin
            tick();
            c++;
        end
        chk("b2b done cycle", c, 9);
        chk("b2b s", s1, 8'h55);
        chk("b2b cout", cout1, 1'b1);
        chk("b2b ovf", ovf1, 1'b1);
        tick();
        tick();

        // reset mid-RUN aborts with no done
        a = 8'h3C; b = 8'h0F; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("pre-abort busy", busy1, 1'b1);
        rst = 1'b1;
        tick();
        chk("abort busy", bz, 0);
        chk("abort done", dn, 0);
        chk("abort s", s1, 0);
        chk("abort cout/ovf", {cout1, ovf1}, 0);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            if (dn != 0) ndone++;
            tick();
        end
        chk("abort no done", ndone, 0);
        chk("abort idle", bz, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/addsub_serial.md
Name: addsub_serial

Overview:
- Parametrised, sequential successor to the team's 2-bit combinational add/sub cell.
- Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, through a digit-serial ripple datapath.
- Provides a start/busy/done handshake, a carry/borrow-out flag and a signed-overflow flag.
- Sits between the operand registers and the result display/ALU-select logic in the lab datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥2.
- DIGIT, 1, bits processed per clock; must divide WIDTH exactly. Elaboration fails otherwise.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- sub  input  1  operation select; 0 = a+b, 1 = a−b; captured with start.
- a  input  WIDTH  operand A; captured with start.
- b  input  WIDTH  operand B; captured with start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- s  output  WIDTH  sum/difference; holds its value until the next accepted start.
- cout  output  1  carry out of the MSB. For subtract, 1 = no borrow (a ≥ b unsigned).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset:
  - rst=1 at a rising edge forces state IDLE.
  - busy, done, s, cout, ovf and the digit counter all go to 0.
  - Reset takes priority over every other input and aborts any RUN in progress; no done is produced for the aborted operation.
- States:
  - IDLE: waits for start.
  - RUN: processes one digit per edge.
  - DONE: presents the result for one cycle.
- IDLE → RUN on an edge with start=1. On that edge:
  - Latch A=a.
  - Latch B = sub ? ~b : b.
  - Set carry = sub.
  - Set counter = 0.
  - Clear s, cout and ovf.
- RUN, each edge:
  - Add digit [counter*DIGIT +: DIGIT] of A, digit [counter*DIGIT +: DIGIT] of B, and carry.
  - Write the DIGIT-bit result into s at the same position.
  - Update carry to the digit's carry-out.
  - Increment counter.
- RUN → DONE on the edge that processes the last digit (counter = WIDTH/DIGIT−1). On that edge:
  - cout = final carry.
  - ovf = carry into the MSB XOR carry out of the MSB.
- DONE lasts exactly one cycle with done=1, then goes to IDLE. If start=1 in DONE, go directly to RUN (back-to-back operation), latching new operands as in IDLE.
- Latency: start accepted at edge k → done high in the cycle after edge k+WIDTH/DIGIT. That gives WIDTH/DIGIT cycles of busy=1. Throughput is one operation per WIDTH/DIGIT+1 cycles.
- busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both high.
- start during RUN is ignored; no queuing. Changes to a, b or sub during RUN do not affect the result.
- s, cout and ovf are undefined-but-stable during RUN. The bench checks them only when done=1 or in the following IDLE cycles. They hold until the next accepted start.
- Arithmetic is modulo 2^WIDTH; there is no saturation.
- WIDTH/DIGIT=1 (DIGIT=WIDTH) is legal: RUN lasts one cycle.

Test Plan:
- WIDTH=8, DIGIT=1; add 0x3C+0x0F → s=0x4B, cout=0, ovf=0. busy high for exactly 8 cycles; done one-cycle pulse on the 9th cycle after start.
- Add 0x7F+0x01 → s=0x80, cout=0, ovf=1. Add 0xFF+0x01 → s=0x00, cout=1, ovf=0.
- Subtract 0x05−0x07 → s=0xFE, cout=0 (borrow), ovf=0. Subtract 0x80−0x01 → s=0x7F, cout=1, ovf=1.
- Start with 0x10+0x20. Pulse start with 0xAA−0x55 at cycle 3 of RUN → ignored, result 0x30. Then assert start during DONE with 0xAA−0x55 → accepted immediately, result s=0x55, cout=1, ovf=1.
- Reset at cycle 4 of RUN → next cycle: busy=0, done=0, s=0x00, cout=0, ovf=0, state IDLE. No done pulse follows.
- WIDTH=8, DIGIT=4; add 0x9C+0x64 → s=0x00, cout=1, ovf=0. busy for 2 cycles, done on the 3rd cycle. Also repeat with DIGIT=8: busy for 1 cycle.
